// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V datapath types: XLEN, writeback source select,
//               load funct3 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load extractor: picks byte/halfword/word from an
//               aligned memory word and sign- or zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data,
  output logic            o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = '0;
    w_half    = '0;
    o_data    = '0;
    o_illegal = 1'b0;

    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase

    // Halfword misalignment is trapped upstream, so only off[1] matters.
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LW:   o_data = i_word;
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register and writeback formatter driving the
//               register file write port and decode forwarding path.
//               Define WB_INSTRET_EN to add the 64-bit retired counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  wb_sel_e         mem_wb_sel,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_word,
  input  logic [XLEN-1:0] mem_pc_plus4,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_write_data,
  output logic            wb_load_fault
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  logic [XLEN-1:0] w_load_data;
  logic            w_load_illegal;
  logic            w_fault;
  logic            w_reg_write;
  logic [XLEN-1:0] w_wb_data;

  logic            r_valid;
  logic            r_reg_write;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;
  logic            r_fault;

  load_align u_load_align (
    .i_word    (mem_load_word),
    .i_off     (mem_alu_result[1:0]),
    .i_funct3  (mem_funct3),
    .o_data    (w_load_data),
    .o_illegal (w_load_illegal)
  );

  always_comb begin
    w_fault   = ((mem_wb_sel == WB_LOAD) && w_load_illegal) || (mem_wb_sel == WB_RSVD);
    w_wb_data = '0;
    case (mem_wb_sel)
      WB_ALU:  w_wb_data = mem_alu_result;
      WB_LOAD: w_wb_data = w_load_data;
      WB_PC4:  w_wb_data = mem_pc_plus4;
      default: w_wb_data = '0;
    endcase
    if (w_fault) w_wb_data = '0;
    w_reg_write = mem_valid && mem_reg_write && (mem_rd != 5'd0) && !w_fault;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
      r_fault     <= 1'b0;
    end else if (!stall) begin
      r_valid     <= mem_valid;
      r_reg_write <= w_reg_write;
      r_rd        <= mem_rd;
      r_data      <= w_wb_data;
      r_fault     <= w_fault;
    end
  end

  assign wb_valid      = r_valid;
  assign wb_reg_write  = r_reg_write;
  assign wb_rd         = r_rd;
  assign wb_write_data = r_data;
  assign wb_load_fault = r_fault;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // Counts on entry into WB, so a stalled instruction is counted only once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_instret <= '0;
    end else if (!flush && !stall && mem_valid) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret = r_instret;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed scoreboard bench for mem_wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;
  import riscv_pkg::*;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            flush;
  logic            mem_valid;
  logic            mem_reg_write;
  logic [4:0]      mem_rd;
  wb_sel_e         mem_wb_sel;
  logic [2:0]      mem_funct3;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_load_word;
  logic [XLEN-1:0] mem_pc_plus4;
  logic            wb_valid;
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_write_data;
  logic            wb_load_fault;
  logic [63:0]     instret_w;

  mem_wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_load_word  (mem_load_word),
    .mem_pc_plus4   (mem_pc_plus4),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_write_data  (wb_write_data),
    .wb_load_fault  (wb_load_fault)
`ifdef WB_INSTRET_EN
    ,
    .instret        (instret_w)
`endif
  );

`ifndef WB_INSTRET_EN
  assign instret_w = 64'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file without read bypass, written from the WB port.
  logic [XLEN-1:0] rf [32];
  always @(posedge clk) begin
    if (wb_reg_write) rf[wb_rd] <= wb_write_data;
  end

  typedef struct {
    string           name;
    logic            valid;
    logic            rw;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            fault;
    logic [63:0]     cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_cnt = 64'd0;

  // Monitor: each active edge produces one WB snapshot to score.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tests = tests + 1;
      if (wb_valid !== e.valid || wb_reg_write !== e.rw || wb_rd !== e.rd ||
          wb_write_data !== e.data || wb_load_fault !== e.fault
`ifdef WB_INSTRET_EN
          || instret_w !== e.cnt
`endif
          ) begin
        fails = fails + 1;
        $display("FAIL %s: got v=%b rw=%b rd=%0d data=%h flt=%b cnt=%0d, want v=%b rw=%b rd=%0d data=%h flt=%b cnt=%0d",
                 e.name, wb_valid, wb_reg_write, wb_rd, wb_write_data, wb_load_fault, instret_w,
                 e.valid, e.rw, e.rd, e.data, e.fault, e.cnt);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic f, input logic s,
                      input logic v, input logic rw, input logic [4:0] rd,
                      input logic [1:0] sel, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] word, input logic [31:0] pc,
                      input logic ev, input logic erw, input logic [4:0] erd,
                      input logic [31:0] edata, input logic efault);
    exp_t x;
    @(negedge clk);
    rst            = r;
    flush          = f;
    stall          = s;
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_wb_sel     = wb_sel_e'(sel);
    mem_funct3     = f3;
    mem_alu_result = alu;
    mem_load_word  = word;
    mem_pc_plus4   = pc;
    if (!r)                 exp_cnt = 64'd0;
    else if (!f && !s && v) exp_cnt = exp_cnt + 64'd1;
    x.name = nm; x.valid = ev; x.rw = erw; x.rd = erd;
    x.data = edata; x.fault = efault; x.cnt = exp_cnt;
    sb_q.push_back(x);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = 1'b0; mem_valid = 1'b0; mem_reg_write = 1'b0;
    mem_rd = '0; mem_wb_sel = WB_ALU; mem_funct3 = '0;
    mem_alu_result = '0; mem_load_word = '0; mem_pc_plus4 = '0;

    //    name          r f s v rw rd  sel f3 alu           word          pc            ev erw erd data          flt
    step("reset0",      0,1,1,1,1, 5, 1, 0, 32'h1003,     32'h80FF1234, 32'h4,        0, 0, 0, 32'h0,        0);
    step("reset1",      0,1,1,1,1, 5, 1, 0, 32'h1003,     32'h80FF1234, 32'h4,        0, 0, 0, 32'h0,        0);
    step("lb",          1,0,0,1,1, 5, 1, 0, 32'h1003,     32'h80FF1234, 32'h0,        1, 1, 5, 32'hFFFFFF80, 0);
    step("lbu",         1,0,0,1,1, 5, 1, 4, 32'h1003,     32'h80FF1234, 32'h0,        1, 1, 5, 32'h00000080, 0);
    step("lh",          1,0,0,1,1, 6, 1, 1, 32'h1002,     32'h80017FFF, 32'h0,        1, 1, 6, 32'hFFFF8001, 0);
    step("lhu",         1,0,0,1,1, 6, 1, 5, 32'h1002,     32'h80017FFF, 32'h0,        1, 1, 6, 32'h00008001, 0);
    step("lh_off0",     1,0,0,1,1, 6, 1, 1, 32'h1000,     32'h80017FFF, 32'h0,        1, 1, 6, 32'h00007FFF, 0);
    step("lh_off3",     1,0,0,1,1, 6, 1, 1, 32'h1003,     32'h80017FFF, 32'h0,        1, 1, 6, 32'hFFFF8001, 0);
    step("lb_off1",     1,0,0,1,1, 8, 1, 0, 32'h2001,     32'h80FF1234, 32'h0,        1, 1, 8, 32'h00000012, 0);
    step("lw",          1,0,0,1,1, 9, 1, 2, 32'h3003,     32'hDEADBEEF, 32'h0,        1, 1, 9, 32'hDEADBEEF, 0);
    step("x0",          1,0,0,1,1, 0, 0, 0, 32'hCAFEF00D, 32'h0,        32'h0,        1, 0, 0, 32'hCAFEF00D, 0);
    step("f3_3",        1,0,0,1,1, 6, 1, 3, 32'h1000,     32'hFFFFFFFF, 32'h0,        1, 0, 6, 32'h0,        1);
    step("f3_6",        1,0,0,1,1, 6, 1, 6, 32'h1000,     32'hFFFFFFFF, 32'h0,        1, 0, 6, 32'h0,        1);
    step("sel3",        1,0,0,1,1, 6, 3, 0, 32'h1000,     32'hFFFFFFFF, 32'h0,        1, 0, 6, 32'h0,        1);
    step("alu_f3x",     1,0,0,1,1,10, 0, 7, 32'h55,       32'h0,        32'h0,        1, 1,10, 32'h55,       0);
    step("pre_stall",   1,0,0,1,1,11, 0, 0, 32'hA5A5,     32'h0,        32'h0,        1, 1,11, 32'hA5A5,     0);
    step("stall1",      1,0,1,1,1,12, 0, 0, 32'h1,        32'h0,        32'h0,        1, 1,11, 32'hA5A5,     0);
    step("stall2",      1,0,1,1,1,12, 0, 0, 32'h1,        32'h0,        32'h0,        1, 1,11, 32'hA5A5,     0);
    step("stall3",      1,0,1,1,1,12, 0, 0, 32'h1,        32'h0,        32'h0,        1, 1,11, 32'hA5A5,     0);
    step("post_stall",  1,0,0,1,1,12, 0, 0, 32'h1,        32'h0,        32'h0,        1, 1,12, 32'h1,        0);
    step("flush_stall", 1,1,1,1,1,13, 0, 0, 32'h2,        32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    step("bubble",      1,0,0,0,1, 3, 0, 0, 32'h77,       32'h0,        32'h0,        0, 0, 3, 32'h77,       0);
    step("pc4",         1,0,0,1,1, 7, 2, 0, 32'h9,        32'h0,        32'h12345678, 1, 1, 7, 32'h12345678, 0);
    step("idle1",       1,0,0,0,0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    step("idle2",       1,0,0,0,0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        0);

    // Two edges after the WB_PC4 capture, x7 is architectural state.
    tests = tests + 1;
    if (rf[7] !== 32'h12345678) begin
      fails = fails + 1;
      $display("FAIL rf_x7: got %h, want %h", rf[7], 32'h12345678);
    end

    step("pre_rst",     1,0,0,1,1,14, 0, 0, 32'hBEEF,     32'h0,        32'h0,        1, 1,14, 32'hBEEF,     0);
    step("rst_stall",   0,0,1,1,1,14, 0, 0, 32'hBEEF,     32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
    step("after_rst",   1,0,0,1,1,15, 0, 0, 32'h10,       32'h0,        32'h0,        1, 1,15, 32'h10,       0);

    repeat (3) @(posedge clk);
    #2;
    tests = tests + 1;
    if (sb_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and writeback formatter between the MEM stage and the register file write port. It captures MEM-stage results and extracts and sign/zero-extends load data. It selects the final writeback value and drives `RegWrite`, `rd` and `write_data` of the register file, plus the same signals for the decode-stage forwarding path. Optionally, it also keeps the retired-instruction counter.

## Interface
- `XLEN`, from `riscv_pkg` (32): datapath width
- `clk` input 1: rising-edge clock
- `rst` input 1: synchronous, active-low reset
- `stall` input 1: hold WB register contents
- `flush` input 1: insert bubble; has priority over `stall`
- `mem_valid` input 1: MEM stage holds a real instruction
- `mem_reg_write` input 1: instruction writes `rd`
- `mem_rd` input 5: destination register
- `mem_wb_sel` input 2 (`wb_sel_e`): result source, one of `WB_ALU`=0, `WB_LOAD`=1, `WB_PC4`=2; 3 is reserved
- `mem_funct3` input 3: load size/sign, LB=0, LH=1, LW=2, LBU=4, LHU=5
- `mem_alu_result` input XLEN: ALU result, which is the byte address for loads
- `mem_load_word` input XLEN: raw aligned word from data memory
- `mem_pc_plus4` input XLEN: link value
- `wb_valid` output 1: WB holds a real instruction
- `wb_reg_write` output 1: to register file `RegWrite`
- `wb_rd` output 5: to register file `rd`
- `wb_write_data` output XLEN: to register file `write_data`
- `wb_load_fault` output 1: WB holds a load with illegal funct3 or wb_sel 3
- `instret` output 64: retired count (present only with `WB_INSTRET_EN`)

## Operation
- Reset (`rst`=0 at a rising edge): all outputs are 0, including `instret`.
- Capture on each rising edge, when `rst`=1:
  - If `flush`=1: `wb_valid`, `wb_reg_write` and `wb_load_fault` become 0. `wb_rd` and `wb_write_data` become 0.
  - Else if `stall`=1: all registers hold.
  - Else: load the formatted MEM values.
- Formatting is combinational on the MEM side; outputs are registered.
  - `off` = `mem_alu_result[1:0]`.
  - LB/LBU: byte `off` of `mem_load_word`, sign- or zero-extended.
  - LH/LHU: halfword `off[1]`, sign- or zero-extended. `off[0]` is ignored because misalignment is trapped upstream.
  - LW: whole word; `off` is ignored.
- Select: `WB_ALU` gives `mem_alu_result`, `WB_LOAD` gives the formatted load, `WB_PC4` gives `mem_pc_plus4`.
- Faults:
  - A load with funct3 of 3, 6 or 7, or wb_sel 3, captures `wb_load_fault`=1, `wb_reg_write`=0 and `wb_write_data`=0.
  - `funct3` is ignored when `wb_sel` is not `WB_LOAD`.
- `wb_reg_write` = `mem_valid & mem_reg_write & (mem_rd != 0) & !fault`. An x0 write is never asserted.
- `wb_valid` = `mem_valid`. A faulting instruction is still valid.

## Timing
- Latency is 1 cycle from MEM inputs to WB outputs. The register file commits one edge later, so there are 2 edges from the MEM stage to architectural state.
- During `stall`, `wb_reg_write` stays asserted. The register file rewrites the same value every cycle, which is harmless.
- The register file has no internal read-after-write bypass. Decode must forward from `wb_rd`/`wb_write_data` when `wb_reg_write`=1 and `wb_rd` equals the source register.
- When `flush` and `stall` are both asserted, the flush wins.
- When `rst`=0 and `flush` are both asserted, reset wins. Reset mid-stall clears the register; the held instruction is lost.

## Configuration
- `WB_INSTRET_EN` defined:
  - A 64-bit `instret` port exists.
  - It increments by 1 at each edge where `rst`=1, `flush`=0, `stall`=0 and `mem_valid`=1. Faulting instructions count.
  - Each instruction counts once, however long it stalls. The counter wraps from 2^64-1 to 0.
- `WB_INSTRET_EN` undefined: the port and counter are absent, and there is no other behavioural change.

## Structure
- Add to `riscv_pkg`:
  - `wb_sel_e` (2-bit enum `WB_ALU`/`WB_LOAD`/`WB_PC4`).
  - Load funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
- Sub-module `load_align`: purely combinational. Inputs are word, offset and funct3; outputs are extended data and an illegal flag. It is reused by any future load-store unit.

## Test plan
- **Reset:** reset with all inputs active → all outputs 0 on the next cycle. `instret`=0.
- **LB:** LB, `alu_result`=0x1003, word=0x80FF_1234, rd=5 → next cycle `wb_write_data`=0xFFFF_FF80 and `wb_reg_write`=1. LBU with the same inputs → 0x0000_0080.
- **LH/LHU, offset 2:** LH, word=0x8001_7FFF → 0xFFFF_8001. LHU → 0x0000_8001.
- **x0 and fault:** rd=0 with an ALU result → `wb_reg_write`=0. funct3=3 load → `wb_load_fault`=1 and data 0.
- **Stall and flush:** stall for 3 cycles → outputs held, `instret` increments once. Assert `flush` and `stall` together → `wb_valid`=0.
- **Register file integration:** write x7=0x1234_5678 via `WB_PC4`, then read rs1=7 two cycles later → 0x1234_5678.
